// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix storage bank: request opcodes, default
// geometry and the row-major element index used by every data path.
package matrix_pkg;

   typedef enum logic [1:0] {
      OP_READ   = 2'd0,
      OP_WRITE  = 2'd1,
      OP_READ_T = 2'd2,
      OP_CLEAR  = 2'd3
   } op_e;

   localparam int DEF_ROWS   = 4;
   localparam int DEF_COLS   = 4;
   localparam int DEF_ELEM_W = 16;
   localparam int DEF_DEPTH  = 8;

   // Element (r,c) of a matrix with the given column count, row-major.
   function automatic int elem_idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

endpackage : matrix_pkg

// File: rtl/matrix_transpose.sv
// Pure wiring transpose: output element (c,r) takes input element (r,c).
// The output is laid out as a COLS x ROWS matrix, which equals ROWS x COLS when square.
module matrix_transpose
   import matrix_pkg::*;
#(
   parameter int ROWS   = DEF_ROWS,
   parameter int COLS   = DEF_COLS,
   parameter int ELEM_W = DEF_ELEM_W
) (
   input  logic [ROWS*COLS*ELEM_W-1:0] in_data,
   output logic [ROWS*COLS*ELEM_W-1:0] out_data
);

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         assign out_data[elem_idx(c, r, ROWS)*ELEM_W +: ELEM_W] =
                in_data[elem_idx(r, c, COLS)*ELEM_W +: ELEM_W];
      end
   end

endmodule : matrix_transpose

// File: rtl/matrix_mem_bank.sv
// Matrix word storage with element-masked write, transposed read and word clear.
// Reads return through a single registered, back-pressured response slot.
module matrix_mem_bank
   import matrix_pkg::*;
#(
   parameter int  ROWS   = DEF_ROWS,
   parameter int  COLS   = DEF_COLS,
   parameter int  ELEM_W = DEF_ELEM_W,
   parameter int  DEPTH  = DEF_DEPTH,
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int MW     = ROWS * COLS * ELEM_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [AW-1:0]        req_addr,
   input  logic [MW-1:0]        req_data,
   input  logic [ROWS*COLS-1:0] req_mask,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [MW-1:0]        rsp_data,
   output logic                 rsp_err
);

   localparam int          NE        = ROWS * COLS;
   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
   localparam bit          SQUARE    = (ROWS == COLS);

   logic [MW-1:0] mem_q [DEPTH];

   logic          rsp_valid_q, rsp_valid_d;
   logic [MW-1:0] rsp_data_q,  rsp_data_d;
   logic          rsp_err_q,   rsp_err_d;

   op_e           op;
   logic          accept;
   logic          addr_ok;
   logic [MW-1:0] rd_word;
   logic [MW-1:0] rd_word_t;
   logic          mem_we;
   logic [MW-1:0] mem_wdata;

   // The response slot frees up in the same cycle it retires, allowing one read per cycle.
   assign req_ready = !rst && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign op        = op_e'(req_op);
   assign addr_ok   = {1'b0, req_addr} < DEPTH_LIM;
   assign rd_word   = addr_ok ? mem_q[req_addr] : '0;

   matrix_transpose #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .ELEM_W (ELEM_W)
   ) u_transpose (
      .in_data  (rd_word),
      .out_data (rd_word_t)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      mem_we      = 1'b0;
      mem_wdata   = rd_word;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      for (int e = 0; e < NE; e++) begin
         if (req_mask[e]) begin
            mem_wdata[e*ELEM_W +: ELEM_W] = req_data[e*ELEM_W +: ELEM_W];
         end
      end

      if (accept) begin
         case (op)
            OP_READ: begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = !addr_ok;
               rsp_data_d  = addr_ok ? rd_word : '0;
            end
            OP_READ_T: begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = !addr_ok || !SQUARE;
               rsp_data_d  = (addr_ok && SQUARE) ? rd_word_t : '0;
            end
            OP_WRITE: begin
               mem_we = addr_ok;
            end
            OP_CLEAR: begin
               mem_we    = addr_ok;
               mem_wdata = '0;
            end
            default: begin
               mem_we = 1'b0;
            end
         endcase
      end
   end

   // NOTE: the storage is a flop array rather than a RAM macro, so it can and must be cleared by the async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[req_addr] <= mem_wdata;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule : matrix_mem_bank
